// File: rtl/pong_pkg.sv
// Shared definitions for the pong design: debounce FSM state encoding and
// default 100 MHz timing constants for the button conditioners.
package pong_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  // 10 ms debounce, 500 ms to first repeat, 100 ms between repeats
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear to 0
// on the asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // first flop may go metastable, second flop gives it a cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes a raw button, debounces it with a
// four-state FSM and produces a stable level, a press pulse and an action
// pulse. Define BTN_AUTOREPEAT_EN to add auto-repeat action pulses while the
// button stays held; without it act_tick is a copy of db_tick.
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_100Mhz,
  input  logic reset,
  input  logic btn,
  output logic db_level,
  output logic db_tick,
  output logic act_tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("btn_conditioner: REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("btn_conditioner: REPEAT_PERIOD must be at least 2");
  end

  logic          btn_s;
  db_state_t     state;
  logic [CW-1:0] db_cnt;
  logic          accept_press;

  sync_2ff u_sync (
    .clk (clk_100Mhz),
    .rst (reset),
    .d   (btn),
    .q   (btn_s)
  );

  // the edge on which a press is accepted: last stable sample in WAIT1
  assign accept_press = (state == WAIT1) && btn_s && (db_cnt == DB_LAST);

  // debounce FSM; db_cnt is cleared on every entry to a WAIT state, so it
  // never needs to wrap
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state    <= ZERO;
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (btn_s) begin
            state  <= WAIT1;
            db_cnt <= '0;
          end
        end
        WAIT1: begin
          if (!btn_s) begin
            state <= ZERO;
          end else if (db_cnt == DB_LAST) begin
            state    <= ONE;
            db_level <= 1'b1;
            db_tick  <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ONE: begin
          if (!btn_s) begin
            state  <= WAIT0;
            db_cnt <= '0;
          end
        end
        WAIT0: begin
          if (btn_s) begin
            state <= ONE;
          end else if (db_cnt == DB_LAST) begin
            state    <= ZERO;
            db_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state <= ZERO;
        end
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          rep_hit;

  // first interval after a press is REPEAT_DELAY, later ones REPEAT_PERIOD
  assign rep_hit = rep_first ? (rep_cnt == RD_LAST) : (rep_cnt == RP_LAST);

  // repeat timer: runs in ONE, holds in the WAIT states, clears in ZERO
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      act_tick  <= 1'b0;
    end else begin
      act_tick <= 1'b0;
      if (accept_press) begin
        act_tick  <= 1'b1;
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (state == ONE) begin
        if (rep_hit) begin
          act_tick  <= 1'b1;
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else if (state == ZERO) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept_press;
  assign act_tick      = db_tick;
`endif

endmodule
